ibexc_rvfi_trace_buf: RTL and testbench
=======================================

Name: ibexc_rvfi_trace_buf

Overview:
- Synthesisable on-chip trace capture for the CHERIoT Ibex core.
- Samples RVFI retirement records, filters them by a runtime-selected mode, and stores them in a parametrised circular buffer.
- Drains stored records as a valid/ready stream of 32-bit words.
- Sits beside ibexc_top, in place of the simulation-only tracer, for FPGA/silicon debug.

Parameters:
- Depth, 16, number of record slots; power of two, at least 2.
- DropCntW, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- mode_i  in  2  capture mode: 0 OFF, 1 ALL, 2 TRAP, 3 PCWIN
- pc_lo_i  in  32  PC window lower bound, inclusive
- pc_hi_i  in  32  PC window upper bound, exclusive
- freeze_on_trap_i  in  1  stop capture after a stored trap record
- clear_i  in  1  flush buffer, zero drop counter, unfreeze
- rvfi_valid_i  in  1  retirement strobe
- rvfi_order_i  in  64  retirement order
- rvfi_insn_i  in  32  instruction
- rvfi_trap_i  in  1  trap flag
- rvfi_intr_i  in  1  interrupt flag
- rvfi_halt_i  in  1  halt flag
- rvfi_mode_i  in  2  privilege mode
- rvfi_pc_rdata_i  in  32  PC
- rvfi_rd_addr_i  in  5  destination register
- rvfi_rd_wdata_i  in  32  destination data
- rvfi_mem_addr_i  in  32  memory address (used only with the optional feature)
- rvfi_mem_rmask_i  in  4  memory read mask (used only with the optional feature)
- rvfi_mem_wmask_i  in  4  memory write mask (used only with the optional feature)
- trace_valid_o  out  1  output word valid
- trace_ready_i  in  1  sink ready
- trace_data_o  out  32  output word
- trace_last_o  out  1  last word of the current record
- count_o  out  $clog2(Depth)+1  stored record count
- drop_cnt_o  out  DropCntW  saturating count of dropped records
- frozen_o  out  1  capture is frozen

Behaviour:
- Reset: buffer empty, pointers and word index 0. All outputs 0: trace_valid_o, trace_data_o, trace_last_o, count_o, drop_cnt_o, frozen_o.
- Reset asserted mid-drain: contents discarded; drain restarts at word 0 after reset.
- Filter, evaluated combinationally in the cycle rvfi_valid_i=1, using mode_i sampled that same cycle:
  - OFF: reject.
  - ALL: accept.
  - TRAP: accept if trap|intr|halt.
  - PCWIN: accept if pc_lo_i <= pc < pc_hi_i, unsigned. If pc_lo_i >= pc_hi_i, reject.
- Capture = valid & accept & !frozen.
- Record layout, NW=4 words (NW=5 with the optional feature):
  - word0 = {order[15:0], rd_addr, priv[1:0], trap, intr, halt, 6'b0}
  - word1 = pc
  - word2 = insn
  - word3 = rd_wdata
- Capture with buffer not full: write at tail, tail+1. The record is visible at trace_valid_o the next cycle.
- Capture with buffer full:
  - If the head record's last word completes a handshake in the same cycle, the capture is accepted.
  - Otherwise the record is dropped and drop_cnt_o increments, saturating at all-ones.
- Drain:
  - trace_valid_o = count_o != 0.
  - trace_data_o = head record word[widx].
  - trace_last_o = valid & (widx == NW-1).
  - On valid & ready: widx+1. On the last word: widx=0, head+1.
  - Data is stable while valid & !ready. No word is skipped or repeated.
- Pointers: log2(Depth)+1 bits with a wrap bit. full = MSBs differ and LSBs equal. count_o = tail - head.
- Freeze:
  - A stored record with trap=1 while freeze_on_trap_i=1 sets frozen_o on the next cycle.
  - While frozen, records are neither stored nor counted as drops. Drain continues.
  - frozen_o clears only on clear_i or reset. Deasserting freeze_on_trap_i does not clear it.
- clear_i: takes effect next cycle and has priority over capture and drain in the same cycle. Result: count 0, widx 0, drop 0, frozen 0, trace_valid_o 0.
- Orders wrap modulo 2^16 in word0; no special handling.

Optional Feature:
- Macro: IBEXC_TRACE_MEM_EN.
- When defined:
  - NW=5; word4 = mem_addr.
  - word0[5:2] = mem_wmask; word0[1] = |mem_rmask.
  - TRAP mode additionally accepts records with nonzero mem_wmask (store watch).
- When undefined:
  - NW=4; word0[5:0]=0.
  - mem ports unused, tied to an unused sink.

Decomposition:
- Package ibexc_trace_pkg holds:
  - trace_mode_e (OFF/ALL/TRAP/PCWIN)
  - trace_rec_t struct
  - TraceRecWords constant, conditioned on the macro
  - word0 field offset constants
- One sub-module: ibexc_trace_fifo, a generic Depth x record circular store with push/pop, full/empty and count.
- Filter, freeze, drop counter and word serialiser live in the top of the block.

Test Plan:
- Mode ALL, 3 retirements pc=0x100/0x104/0x108, ready=1 → 12 words; word1 values 0x100, 0x104, 0x108; trace_last_o on words 3, 7, 11; count_o returns to 0.
- Depth=16, ready=0, 20 retirements → count_o=16, drop_cnt_o=4; drain yields the first 16 orders.
- Full buffer, ready=1 on the last word coincident with a capture → no drop; count_o stays 16.
- Mode PCWIN lo=0x200 hi=0x300, pcs 0x1FC/0x200/0x2FC/0x300 → only 0x200 and 0x2FC stored. With lo=hi=0x200 → nothing stored.
- freeze_on_trap_i=1, retirements with trap=0,1,0 → 2 stored, frozen_o=1, drop_cnt_o=0; then clear_i → count_o=0, frozen_o=0.
- Random ready back-pressure for 1000 records, compared against a scoreboard → exact word sequence; data held stable while stalled; rst_i asserted mid-drain → trace_valid_o=0 next cycle.

Source files
------------

// File: rtl/ibexc_rvfi_trace_buf_pkg.sv
// Shared types and constants for the RVFI trace buffer.
// IBEXC_TRACE_MEM_EN adds a memory-address word and mem fields in word0.
package ibexc_trace_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ALL   = 2'd1,
    MODE_TRAP  = 2'd2,
    MODE_PCWIN = 2'd3
  } trace_mode_e;

`ifdef IBEXC_TRACE_MEM_EN
  localparam int unsigned TraceRecWords = 5;
`else
  localparam int unsigned TraceRecWords = 4;
`endif

  localparam int unsigned W0OrderLsb = 16;
  localparam int unsigned W0RdLsb    = 11;
  localparam int unsigned W0PrivLsb  = 9;
  localparam int unsigned W0TrapBit  = 8;
  localparam int unsigned W0IntrBit  = 7;
  localparam int unsigned W0HaltBit  = 6;
  localparam int unsigned W0WmaskLsb = 2;
  localparam int unsigned W0RmaskBit = 1;

  typedef struct packed {
`ifdef IBEXC_TRACE_MEM_EN
    logic [31:0] mem_addr;
`endif
    logic [31:0] rd_wdata;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] word0;
  } trace_rec_t;

  function automatic logic [31:0] rec_word(trace_rec_t rec, logic [2:0] idx);
    logic [31:0] w;
    case (idx)
      3'd0:    w = rec.word0;
      3'd1:    w = rec.pc;
      3'd2:    w = rec.insn;
      3'd3:    w = rec.rd_wdata;
`ifdef IBEXC_TRACE_MEM_EN
      3'd4:    w = rec.mem_addr;
`endif
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ibexc_rvfi_trace_buf_if.sv
// Trace output stream: valid/ready word stream with end-of-record marker.
interface ibexc_rvfi_trace_buf_if;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_data_o;
  logic        trace_last_o;

  modport master (output trace_valid_o, output trace_data_o, output trace_last_o,
                  input trace_ready_i);
  modport slave  (input trace_valid_o, input trace_data_o, input trace_last_o,
                  output trace_ready_i);
endinterface

// File: rtl/ibexc_trace_fifo.sv
// Depth-slot circular record store with wrap-bit pointers.
module ibexc_trace_fifo
  import ibexc_trace_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  trace_rec_t             wdata,
  input  logic                   pop,
  output trace_rec_t             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);
  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;
  trace_rec_t  mem [Depth];

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  // A full store may still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/ibexc_rvfi_trace_buf.sv
// On-chip RVFI trace capture: filter, freeze-on-trap, drop counter, word serialiser.
// Optional IBEXC_TRACE_MEM_EN: 5-word records with memory address and store watch.
module ibexc_rvfi_trace_buf
  import ibexc_trace_pkg::*;
#(
  parameter int unsigned Depth    = 16,
  parameter int unsigned DropCntW = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             mode_i,
  input  logic [31:0]            pc_lo_i,
  input  logic [31:0]            pc_hi_i,
  input  logic                   freeze_on_trap_i,
  input  logic                   clear_i,
  input  logic                   rvfi_valid_i,
  input  logic [63:0]            rvfi_order_i,
  input  logic [31:0]            rvfi_insn_i,
  input  logic                   rvfi_trap_i,
  input  logic                   rvfi_intr_i,
  input  logic                   rvfi_halt_i,
  input  logic [1:0]             rvfi_mode_i,
  input  logic [31:0]            rvfi_pc_rdata_i,
  input  logic [4:0]             rvfi_rd_addr_i,
  input  logic [31:0]            rvfi_rd_wdata_i,
  input  logic [31:0]            rvfi_mem_addr_i,
  input  logic [3:0]             rvfi_mem_rmask_i,
  input  logic [3:0]             rvfi_mem_wmask_i,
  ibexc_rvfi_trace_buf_if.master trace,
  output logic [$clog2(Depth):0] count_o,
  output logic [DropCntW-1:0]    drop_cnt_o,
  output logic                   frozen_o
);
  localparam int unsigned WIdxW = $clog2(TraceRecWords);

  trace_mode_e          mode;
  trace_rec_t           rec_in, head_rec;
  logic                 accept, capture, push, drop;
  logic                 full, empty, valid, word_hs, last_word;
  logic [WIdxW-1:0]     widx;
  logic [DropCntW-1:0]  drop_q;
  logic                 frozen_q;

  assign mode = trace_mode_e'(mode_i);

  always_comb begin
    accept = 1'b0;
    case (mode)
      MODE_ALL:   accept = 1'b1;
`ifdef IBEXC_TRACE_MEM_EN
      MODE_TRAP:  accept = rvfi_trap_i | rvfi_intr_i | rvfi_halt_i | (|rvfi_mem_wmask_i);
`else
      MODE_TRAP:  accept = rvfi_trap_i | rvfi_intr_i | rvfi_halt_i;
`endif
      MODE_PCWIN: accept = (rvfi_pc_rdata_i >= pc_lo_i) && (rvfi_pc_rdata_i < pc_hi_i);
      default:    accept = 1'b0;
    endcase
  end

  always_comb begin
    rec_in = '0;
    rec_in.word0[W0OrderLsb +: 16] = rvfi_order_i[15:0];
    rec_in.word0[W0RdLsb +: 5]     = rvfi_rd_addr_i;
    rec_in.word0[W0PrivLsb +: 2]   = rvfi_mode_i;
    rec_in.word0[W0TrapBit]        = rvfi_trap_i;
    rec_in.word0[W0IntrBit]        = rvfi_intr_i;
    rec_in.word0[W0HaltBit]        = rvfi_halt_i;
    rec_in.pc                      = rvfi_pc_rdata_i;
    rec_in.insn                    = rvfi_insn_i;
    rec_in.rd_wdata                = rvfi_rd_wdata_i;
`ifdef IBEXC_TRACE_MEM_EN
    rec_in.word0[W0WmaskLsb +: 4]  = rvfi_mem_wmask_i;
    rec_in.word0[W0RmaskBit]       = |rvfi_mem_rmask_i;
    rec_in.mem_addr                = rvfi_mem_addr_i;
`endif
  end

`ifndef IBEXC_TRACE_MEM_EN
  logic unused_mem;
  assign unused_mem = ^{rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i};
`endif
  logic unused_order;
  assign unused_order = ^rvfi_order_i[63:16];

  assign valid     = !empty;
  assign last_word = (widx == WIdxW'(TraceRecWords - 1));
  assign word_hs   = valid && trace.trace_ready_i;
  assign capture   = rvfi_valid_i && accept && !frozen_q;
  assign push      = capture && (!full || (word_hs && last_word));
  assign drop      = capture && !push;

  ibexc_trace_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (clear_i),
    .push  (push),
    .wdata (rec_in),
    .pop   (word_hs && last_word),
    .rdata (head_rec),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      widx     <= '0;
      drop_q   <= '0;
      frozen_q <= 1'b0;
    end else if (clear_i) begin
      widx     <= '0;
      drop_q   <= '0;
      frozen_q <= 1'b0;
    end else begin
      if (word_hs) widx <= last_word ? '0 : widx + WIdxW'(1);
      if (push && rvfi_trap_i && freeze_on_trap_i) frozen_q <= 1'b1;
      if (drop && (drop_q != '1)) drop_q <= drop_q + DropCntW'(1);
    end
  end

  // Gated so that unwritten slots never leak onto the bus.
  assign trace.trace_valid_o = valid;
  assign trace.trace_data_o  = valid ? rec_word(head_rec, 3'(widx)) : '0;
  assign trace.trace_last_o  = valid && last_word;
  assign drop_cnt_o          = drop_q;
  assign frozen_o            = frozen_q;
endmodule

// File: tb/tb_ibexc_rvfi_trace_buf.sv
// Self-checking bench for ibexc_rvfi_trace_buf: filter vector table, directed corners, random drain.
module tb_ibexc_rvfi_trace_buf;
  import ibexc_trace_pkg::*;

  localparam int unsigned Depth = 16;
  localparam int unsigned NW    = TraceRecWords;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [31:0] pc_lo = '0, pc_hi = '0;
  logic        freeze = 1'b0, clr = 1'b0;
  logic        rvfi_valid = 1'b0;
  logic [63:0] rvfi_order = '0;
  logic [31:0] rvfi_insn = '0, rvfi_pc = '0, rvfi_wdata = '0, rvfi_mem_addr = '0;
  logic        rvfi_trap = 1'b0, rvfi_intr = 1'b0, rvfi_halt = 1'b0;
  logic [1:0]  rvfi_priv = '0;
  logic [4:0]  rvfi_rd = '0;
  logic [3:0]  rvfi_rmask = '0, rvfi_wmask = '0;
  logic [4:0]  count;
  logic [15:0] drop_cnt;
  logic        frozen;

  ibexc_rvfi_trace_buf_if trace_if ();

  ibexc_rvfi_trace_buf #(.Depth(Depth), .DropCntW(16)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .pc_lo_i(pc_lo), .pc_hi_i(pc_hi),
    .freeze_on_trap_i(freeze), .clear_i(clr), .rvfi_valid_i(rvfi_valid),
    .rvfi_order_i(rvfi_order), .rvfi_insn_i(rvfi_insn), .rvfi_trap_i(rvfi_trap),
    .rvfi_intr_i(rvfi_intr), .rvfi_halt_i(rvfi_halt), .rvfi_mode_i(rvfi_priv),
    .rvfi_pc_rdata_i(rvfi_pc), .rvfi_rd_addr_i(rvfi_rd), .rvfi_rd_wdata_i(rvfi_wdata),
    .rvfi_mem_addr_i(rvfi_mem_addr), .rvfi_mem_rmask_i(rvfi_rmask),
    .rvfi_mem_wmask_i(rvfi_wmask), .trace(trace_if), .count_o(count),
    .drop_cnt_o(drop_cnt), .frozen_o(frozen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] dq[$];
  logic        lq[$];
  logic [31:0] mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0][31:0] cur_words();
    logic [4:0][31:0] w;
    w = '0;
    w[0] = {rvfi_order[15:0], rvfi_rd, rvfi_priv, rvfi_trap, rvfi_intr, rvfi_halt, 6'b0};
    w[1] = rvfi_pc;
    w[2] = rvfi_insn;
    w[3] = rvfi_wdata;
`ifdef IBEXC_TRACE_MEM_EN
    w[0][5:2] = rvfi_wmask;
    w[0][1]   = |rvfi_rmask;
    w[4]      = rvfi_mem_addr;
`endif
    return w;
  endfunction

  task automatic set_rec(input logic [63:0] ord, input logic [31:0] pc,
                         input logic t, input logic i, input logic h);
    rvfi_order    = ord;
    rvfi_pc       = pc;
    rvfi_insn     = 32'h0000_0013 ^ {ord[15:0], 16'h0};
    rvfi_rd       = ord[4:0];
    rvfi_priv     = ord[1:0];
    rvfi_wdata    = pc ^ 32'hA5A5_5A5A;
    rvfi_mem_addr = pc + 32'd64;
    rvfi_rmask    = ord[3:0];
    rvfi_wmask    = 4'h0;
    rvfi_trap     = t;
    rvfi_intr     = i;
    rvfi_halt     = h;
  endtask

  task automatic retire();
    rvfi_valid = 1'b1;
    @(negedge clk);
    rvfi_valid = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic drain(input int unsigned nwords);
    int unsigned guard;
    guard = 0;
    dq.delete();
    lq.delete();
    trace_if.trace_ready_i = 1'b1;
    while (dq.size() < nwords && guard < 2000) begin
      if (trace_if.trace_valid_o) begin
        dq.push_back(trace_if.trace_data_o);
        lq.push_back(trace_if.trace_last_o);
      end
      @(negedge clk);
      guard++;
    end
    trace_if.trace_ready_i = 1'b0;
    chk("drain_words", dq.size(), nwords);
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [31:0] pc, lo, hi;
    logic        t, i, h;
    logic        stored;
  } filt_vec_t;

  filt_vec_t fv[13];

  initial begin
    logic [4:0][31:0] w;
    int unsigned sz, recs, mdrop, exp_cnt;
    logic rdy, ret, pop_last, mfull, stalled;
    logic [31:0] prev_data;

    trace_if.trace_ready_i = 1'b0;
    fv[0]  = '{2'd0, 32'h100, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b0};
    fv[1]  = '{2'd1, 32'h100, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b1};
    fv[2]  = '{2'd2, 32'h100, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b0};
    fv[3]  = '{2'd2, 32'h104, 32'h0,   32'h0,   1'b1, 1'b0, 1'b0, 1'b1};
    fv[4]  = '{2'd2, 32'h108, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0, 1'b1};
    fv[5]  = '{2'd2, 32'h10C, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1};
    fv[6]  = '{2'd3, 32'h1FC, 32'h200, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0};
    fv[7]  = '{2'd3, 32'h200, 32'h200, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1};
    fv[8]  = '{2'd3, 32'h2FC, 32'h200, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1};
    fv[9]  = '{2'd3, 32'h300, 32'h200, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0};
    fv[10] = '{2'd3, 32'h200, 32'h200, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0};
    fv[11] = '{2'd3, 32'h250, 32'h300, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0};
    fv[12] = '{2'd1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    @(negedge clk);
    chk("rst_valid", trace_if.trace_valid_o, 0);
    chk("rst_data", trace_if.trace_data_o, 0);
    chk("rst_last", trace_if.trace_last_o, 0);
    chk("rst_count", count, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_frozen", frozen, 0);
    rst = 1'b0;
    @(negedge clk);

    // Filter table
    for (int k = 0; k < 13; k++) begin
      do_clear();
      mode  = fv[k].md;
      pc_lo = fv[k].lo;
      pc_hi = fv[k].hi;
      set_rec(64'(k) + 64'h1_0000, fv[k].pc, fv[k].t, fv[k].i, fv[k].h);
      w = cur_words();
      retire();
      chk($sformatf("filt%0d_count", k), count, 5'(fv[k].stored));
      if (fv[k].stored) begin
        chk($sformatf("filt%0d_w0", k), trace_if.trace_data_o, w[0]);
        chk($sformatf("filt%0d_last", k), trace_if.trace_last_o, 0);
      end else begin
        chk($sformatf("filt%0d_valid", k), trace_if.trace_valid_o, 0);
      end
    end

    // Three records, full drain
    do_clear();
    mode = 2'd1;
    for (int r = 0; r < 3; r++) begin
      set_rec(64'(r), 32'h100 + 32'(4 * r), 1'b0, 1'b0, 1'b0);
      retire();
    end
    chk("three_count", count, 3);
    drain(3 * NW);
    for (int r = 0; r < 3; r++)
      chk($sformatf("three_pc%0d", r), dq[r * NW + 1], 32'h100 + 32'(4 * r));
    for (int j = 0; j < 3 * NW; j++)
      chk($sformatf("three_last%0d", j), lq[j], ((j % NW) == NW - 1));
    chk("three_count_end", count, 0);

    // Overflow: 20 into 16 slots
    do_clear();
    for (int r = 0; r < 20; r++) begin
      set_rec(64'(100 + r), 32'h400 + 32'(4 * r), 1'b0, 1'b0, 1'b0);
      retire();
    end
    chk("ovf_count", count, 16);
    chk("ovf_drop", drop_cnt, 4);
    drain(16 * NW);
    for (int r = 0; r < 16; r++)
      chk($sformatf("ovf_order%0d", r), dq[r * NW][31:16], 16'(100 + r));
    chk("ovf_count_end", count, 0);

    // Full buffer, last-word handshake coincident with capture
    do_clear();
    for (int r = 0; r < 16; r++) begin
      set_rec(64'(200 + r), 32'h800 + 32'(4 * r), 1'b0, 1'b0, 1'b0);
      retire();
    end
    trace_if.trace_ready_i = 1'b1;
    for (int j = 0; j < NW - 1; j++) @(negedge clk);
    chk("coinc_last", trace_if.trace_last_o, 1);
    set_rec(64'd300, 32'hC00, 1'b0, 1'b0, 1'b0);
    rvfi_valid = 1'b1;
    @(negedge clk);
    rvfi_valid = 1'b0;
    trace_if.trace_ready_i = 1'b0;
    chk("coinc_count", count, 16);
    chk("coinc_drop", drop_cnt, 0);
    set_rec(64'd301, 32'hC04, 1'b0, 1'b0, 1'b0);
    retire();
    chk("full_drop", drop_cnt, 1);
    drain(16 * NW);
    chk("coinc_head", dq[0][31:16], 16'd201);
    chk("coinc_tail", dq[15 * NW][31:16], 16'd300);

    // PC window sequence
    do_clear();
    mode = 2'd3; pc_lo = 32'h200; pc_hi = 32'h300;
    set_rec(64'd1, 32'h1FC, 1'b0, 1'b0, 1'b0); retire();
    set_rec(64'd2, 32'h200, 1'b0, 1'b0, 1'b0); retire();
    set_rec(64'd3, 32'h2FC, 1'b0, 1'b0, 1'b0); retire();
    set_rec(64'd4, 32'h300, 1'b0, 1'b0, 1'b0); retire();
    chk("pcwin_count", count, 2);
    drain(2 * NW);
    chk("pcwin_pc0", dq[1], 32'h200);
    chk("pcwin_pc1", dq[NW + 1], 32'h2FC);

    // Freeze on trap
    do_clear();
    mode = 2'd1; freeze = 1'b1;
    set_rec(64'd10, 32'h500, 1'b0, 1'b0, 1'b0); retire();
    chk("frz_pre", frozen, 0);
    set_rec(64'd11, 32'h504, 1'b1, 1'b0, 1'b0); retire();
    chk("frz_set", frozen, 1);
    set_rec(64'd12, 32'h508, 1'b0, 1'b0, 1'b0); retire();
    chk("frz_count", count, 2);
    chk("frz_drop", drop_cnt, 0);
    freeze = 1'b0;
    set_rec(64'd13, 32'h50C, 1'b0, 1'b0, 1'b0); retire();
    chk("frz_sticky", frozen, 1);
    chk("frz_count2", count, 2);
    do_clear();
    chk("clr_count", count, 0);
    chk("clr_frozen", frozen, 0);
    chk("clr_valid", trace_if.trace_valid_o, 0);
    chk("clr_drop", drop_cnt, 0);
    set_rec(64'd14, 32'h510, 1'b0, 1'b0, 1'b0);
    rvfi_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    rvfi_valid = 1'b0; clr = 1'b0;
    chk("clr_prio", count, 0);

    // Random back-pressure against a word-queue model
    mq.delete();
    recs = 0; mdrop = 0; stalled = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 20000 && recs < 1000; cyc++) begin
      sz = mq.size();
      exp_cnt = (sz + NW - 1) / NW;
      chk("rnd_valid", trace_if.trace_valid_o, (sz != 0));
      chk("rnd_count", count, exp_cnt);
      chk("rnd_drop", drop_cnt, mdrop);
      if (sz != 0) begin
        chk("rnd_data", trace_if.trace_data_o, mq[0]);
        chk("rnd_last", trace_if.trace_last_o, ((sz % NW) == 1));
      end
      if (stalled) chk("rnd_stable", trace_if.trace_data_o, prev_data);
      rdy = 1'($urandom_range(0, 1));
      ret = ($urandom_range(0, 9) < 6);
      if (ret) begin
        set_rec({32'h0, $urandom}, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        recs++;
      end
      trace_if.trace_ready_i = rdy;
      rvfi_valid = ret;
      w = cur_words();
      pop_last = rdy && (sz != 0) && ((sz % NW) == 1);
      mfull = (exp_cnt == Depth);
      if (rdy && sz != 0) void'(mq.pop_front());
      if (ret) begin
        if (!mfull || pop_last) for (int j = 0; j < NW; j++) mq.push_back(w[j]);
        else mdrop++;
      end
      stalled = (sz != 0) && !rdy;
      prev_data = trace_if.trace_data_o;
      @(negedge clk);
    end
    rvfi_valid = 1'b0;
    trace_if.trace_ready_i = 1'b0;
    chk("rnd_records", recs, 1000);

    // Reset during drain
    do_clear();
    for (int r = 0; r < 3; r++) begin
      set_rec(64'(600 + r), 32'h900 + 32'(4 * r), 1'b0, 1'b0, 1'b0);
      retire();
    end
    trace_if.trace_ready_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", trace_if.trace_valid_o, 0);
    chk("rstmid_count", count, 0);
    chk("rstmid_data", trace_if.trace_data_o, 0);
    rst = 1'b0;
    trace_if.trace_ready_i = 1'b0;
    set_rec(64'd700, 32'hA00, 1'b0, 1'b0, 1'b0);
    w = cur_words();
    retire();
    chk("rstmid_w0", trace_if.trace_data_o, w[0]);
    chk("rstmid_last", trace_if.trace_last_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
